// File: rtl/data_mem_controller_if.sv
// Bundle of per-port data-memory request/response signals. One instance
// carries the consumer (LSU) side of the controller, another the memory side.
//
// Handshake: the requester raises read_valid/write_valid together with the
// address (and write data) and keeps valid high until it sees ready. The
// responder raises ready once the access is done, with read_data valid in
// that same cycle. On the memory side ready is a single-cycle pulse and the
// requester drops valid right after it. On the consumer side ready stays high
// until the consumer drops its valid, and falls in the following cycle.
interface data_mem_controller_if #(
   parameter int NUM_PORTS = 1,
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 8
);
   logic [NUM_PORTS-1:0] read_valid;
   logic [ADDR_BITS-1:0] read_address  [NUM_PORTS];
   logic [NUM_PORTS-1:0] read_ready;
   logic [DATA_BITS-1:0] read_data     [NUM_PORTS];
   logic [NUM_PORTS-1:0] write_valid;
   logic [ADDR_BITS-1:0] write_address [NUM_PORTS];
   logic [DATA_BITS-1:0] write_data    [NUM_PORTS];
   logic [NUM_PORTS-1:0] write_ready;

   // Requesting side: LSUs towards the controller, controller towards memory.
   modport master (
      output read_valid, read_address,
      input  read_ready, read_data,
      output write_valid, write_address, write_data,
      input  write_ready
   );

   // Responding side: controller towards LSUs, memory towards controller.
   modport slave (
      input  read_valid, read_address,
      output read_ready, read_data,
      input  write_valid, write_address, write_data,
      output write_ready
   );
endinterface

// File: rtl/data_mem_controller.sv
// data_mem_controller: shares NUM_CHANNELS data-memory channels among
// NUM_CONSUMERS LSU requesters. Every channel runs its own small FSM that
// claims one pending consumer request, relays it to memory and hands the
// response (read data or write acknowledge) back to that consumer.
// Arbitration is fixed priority: lowest channel index claims first, and each
// channel takes the lowest-index consumer nobody owns yet.
module data_mem_controller #(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 8,
   parameter int NUM_CONSUMERS = 4,
   parameter int NUM_CHANNELS  = 1,
   parameter int WRITE_ENABLE  = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   data_mem_controller_if.slave        consumer,
   data_mem_controller_if.master       mem,
   output logic [3*NUM_CHANNELS-1:0]   dbg_state_o
);

   localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

   typedef enum logic [2:0] {
      S_IDLE           = 3'd0,
      S_READ_WAITING   = 3'd1,
      S_WRITE_WAITING  = 3'd2,
      S_READ_RELAYING  = 3'd3,
      S_WRITE_RELAYING = 3'd4
   } state_e;

   // Per-channel state
   state_e                   state_q        [NUM_CHANNELS];
   logic [CW-1:0]            cur_q          [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0]  mem_rd_valid_q;
   logic [NUM_CHANNELS-1:0]  mem_wr_valid_q;
   logic [ADDR_BITS-1:0]     mem_rd_addr_q  [NUM_CHANNELS];
   logic [ADDR_BITS-1:0]     mem_wr_addr_q  [NUM_CHANNELS];
   logic [DATA_BITS-1:0]     mem_wr_data_q  [NUM_CHANNELS];

   // Per-consumer state
   logic [NUM_CONSUMERS-1:0] cons_rd_ready_q;
   logic [NUM_CONSUMERS-1:0] cons_wr_ready_q;
   logic [DATA_BITS-1:0]     cons_rd_data_q [NUM_CONSUMERS];
   logic [NUM_CONSUMERS-1:0] serving_q;

   // Grant decisions for the current cycle
   logic [NUM_CHANNELS-1:0]  grant_valid;
   logic [NUM_CHANNELS-1:0]  grant_read;
   logic [CW-1:0]            grant_idx      [NUM_CHANNELS];
   logic [NUM_CONSUMERS-1:0] taken;
   logic [NUM_CONSUMERS-1:0] write_req;

   // A read-only build never sees write requests, so they can never win a channel.
   assign write_req = (WRITE_ENABLE != 0) ? consumer.write_valid : '0;

   // Fixed-priority grant: idle channels in ascending order each take the
   // lowest unowned requester; a consumer claimed by an earlier channel in the
   // same cycle is already marked taken for the later ones.
   always_comb begin
      taken       = serving_q;
      grant_valid = '0;
      grant_read  = '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         grant_idx[ch] = '0;
      end
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         if (state_q[ch] == S_IDLE) begin
            for (int c = 0; c < NUM_CONSUMERS; c++) begin
               if (!grant_valid[ch] && !taken[c] &&
                   (consumer.read_valid[c] || write_req[c])) begin
                  grant_valid[ch] = 1'b1;
                  grant_idx[ch]   = CW'(c);
                  // Read wins when a consumer asserts both.
                  grant_read[ch]  = consumer.read_valid[c];
                  taken[c]        = 1'b1;
               end
            end
         end
      end
   end

   // Channel FSMs together with every registered output they own.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            state_q[ch]       <= S_IDLE;
            cur_q[ch]         <= '0;
            mem_rd_addr_q[ch] <= '0;
            mem_wr_addr_q[ch] <= '0;
            mem_wr_data_q[ch] <= '0;
         end
         for (int c = 0; c < NUM_CONSUMERS; c++) begin
            cons_rd_data_q[c] <= '0;
         end
         mem_rd_valid_q  <= '0;
         mem_wr_valid_q  <= '0;
         cons_rd_ready_q <= '0;
         cons_wr_ready_q <= '0;
         serving_q       <= '0;
      end else begin
         for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            case (state_q[ch])
               S_IDLE: begin
                  if (grant_valid[ch]) begin
                     // Address and data are captured only here; the consumer
                     // may change them afterwards without effect.
                     cur_q[ch]                 <= grant_idx[ch];
                     serving_q[grant_idx[ch]] <= 1'b1;
                     if (grant_read[ch]) begin
                        mem_rd_valid_q[ch] <= 1'b1;
                        mem_rd_addr_q[ch]  <= consumer.read_address[grant_idx[ch]];
                        state_q[ch]        <= S_READ_WAITING;
                     end else begin
                        mem_wr_valid_q[ch] <= 1'b1;
                        mem_wr_addr_q[ch]  <= consumer.write_address[grant_idx[ch]];
                        mem_wr_data_q[ch]  <= consumer.write_data[grant_idx[ch]];
                        state_q[ch]        <= S_WRITE_WAITING;
                     end
                  end
               end
               S_READ_WAITING: begin
                  if (mem.read_ready[ch]) begin
                     mem_rd_valid_q[ch]         <= 1'b0;
                     cons_rd_ready_q[cur_q[ch]] <= 1'b1;
                     cons_rd_data_q[cur_q[ch]]  <= mem.read_data[ch];
                     state_q[ch]                <= S_READ_RELAYING;
                  end
               end
               S_WRITE_WAITING: begin
                  if (mem.write_ready[ch]) begin
                     mem_wr_valid_q[ch]         <= 1'b0;
                     cons_wr_ready_q[cur_q[ch]] <= 1'b1;
                     state_q[ch]                <= S_WRITE_RELAYING;
                  end
               end
               S_READ_RELAYING: begin
                  // Hold ready until the consumer lets go of its request.
                  if (!consumer.read_valid[cur_q[ch]]) begin
                     cons_rd_ready_q[cur_q[ch]] <= 1'b0;
                     serving_q[cur_q[ch]]       <= 1'b0;
                     state_q[ch]                <= S_IDLE;
                  end
               end
               S_WRITE_RELAYING: begin
                  if (!consumer.write_valid[cur_q[ch]]) begin
                     cons_wr_ready_q[cur_q[ch]] <= 1'b0;
                     serving_q[cur_q[ch]]       <= 1'b0;
                     state_q[ch]                <= S_IDLE;
                  end
               end
               default: begin
                  state_q[ch] <= S_IDLE;
               end
            endcase
         end
      end
   end

   // Consumer-facing outputs come straight from registers.
   assign consumer.read_ready  = cons_rd_ready_q;
   assign consumer.write_ready = (WRITE_ENABLE != 0) ? cons_wr_ready_q : '0;

   for (genvar c = 0; c < NUM_CONSUMERS; c++) begin : g_cons
      assign consumer.read_data[c] = cons_rd_data_q[c];
   end

   // Memory-facing outputs; write outputs are constant zero in a read-only build.
   assign mem.read_valid  = mem_rd_valid_q;
   assign mem.write_valid = (WRITE_ENABLE != 0) ? mem_wr_valid_q : '0;

   for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan
      assign mem.read_address[ch]  = mem_rd_addr_q[ch];
      assign mem.write_address[ch] = (WRITE_ENABLE != 0) ? mem_wr_addr_q[ch] : '0;
      assign mem.write_data[ch]    = (WRITE_ENABLE != 0) ? mem_wr_data_q[ch] : '0;
      assign dbg_state_o[3*ch +: 3] = state_q[ch];
   end

endmodule
